// File: rtl/time_counter.sv
// time_counter: 24-hour BCD HH:MM time-of-day counter fed by timegen strobes.
// Optional feature macro: TIME_COUNTER_SECONDS_EN
//   defined   -> adds a BCD seconds register (current_sec); one_second drives
//                the count and one_minute is ignored.
//   undefined -> minutes advance on one_minute; one_second is ignored.
module time_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_minute,
  input  logic        one_second,
  input  logic        load_new_c,
  input  logic [15:0] new_time,
  output logic [15:0] current_time,
  output logic        hour_tick,
  output logic        day_tick,
  output logic        load_err
`ifdef TIME_COUNTER_SECONDS_EN
  ,
  output logic [7:0]  current_sec
`endif
);

  localparam int unsigned DigitW = 4;
  localparam int unsigned TimeW  = 4 * DigitW;

  // BCD time-of-day, packed exactly like new_time/current_time
  typedef struct packed {
    logic [DigitW-1:0] ms_hr;
    logic [DigitW-1:0] ls_hr;
    logic [DigitW-1:0] ms_min;
    logic [DigitW-1:0] ls_min;
  } bcd_time_t;

  bcd_time_t time_q, time_d;
  bcd_time_t load_time_c;
  logic      hour_tick_q, hour_tick_d;
  logic      day_tick_q, day_tick_d;
  logic      load_err_q, load_err_d;
  logic      load_valid_c;
  logic      minute_adv_c;

  assign load_time_c = bcd_time_t'(new_time[TimeW-1:0]);

  // Load validation: all digits decimal, minutes <= 59, hours <= 23
  always_comb begin
    load_valid_c = 1'b1;
    if (load_time_c.ls_min > DigitW'(9)) load_valid_c = 1'b0;
    if (load_time_c.ms_min > DigitW'(5)) load_valid_c = 1'b0;
    if (load_time_c.ls_hr  > DigitW'(9)) load_valid_c = 1'b0;
    if (load_time_c.ms_hr  > DigitW'(2)) load_valid_c = 1'b0;
    if ((load_time_c.ms_hr == DigitW'(2)) && (load_time_c.ls_hr > DigitW'(3))) load_valid_c = 1'b0;
  end

`ifdef TIME_COUNTER_SECONDS_EN
  logic [DigitW-1:0] sec_ls_q, sec_ls_d;
  logic [DigitW-1:0] sec_ms_q, sec_ms_d;
  logic              unused_minute_c;

  // Minute strobe is superseded by the local seconds count
  assign unused_minute_c = one_minute;

  // A minute advance is produced by the seconds 59 -> 00 wrap
  assign minute_adv_c = one_second && (sec_ms_q == DigitW'(5)) && (sec_ls_q == DigitW'(9));

  // Seconds next state: valid load clears, otherwise count on one_second
  always_comb begin
    sec_ls_d = sec_ls_q;
    sec_ms_d = sec_ms_q;
    if (load_new_c && load_valid_c) begin
      sec_ls_d = '0;
      sec_ms_d = '0;
    end else if (one_second) begin
      if (sec_ls_q == DigitW'(9)) begin
        sec_ls_d = '0;
        if (sec_ms_q == DigitW'(5)) begin
          sec_ms_d = '0;
        end else begin
          sec_ms_d = sec_ms_q + DigitW'(1);
        end
      end else begin
        sec_ls_d = sec_ls_q + DigitW'(1);
      end
    end
  end

  // Seconds register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_ls_q <= '0;
      sec_ms_q <= '0;
    end else begin
      sec_ls_q <= sec_ls_d;
      sec_ms_q <= sec_ms_d;
    end
  end

  assign current_sec = {sec_ms_q, sec_ls_q};
`else
  logic unused_second_c;

  // Seconds strobe has no consumer in the minute-only build
  assign unused_second_c = one_second;

  assign minute_adv_c = one_minute;
`endif

  // Time next state: valid load wins; otherwise advance and flag bad loads
  always_comb begin
    time_d      = time_q;
    hour_tick_d = 1'b0;
    day_tick_d  = 1'b0;
    load_err_d  = 1'b0;
    if (load_new_c && load_valid_c) begin
      time_d = load_time_c;
    end else begin
      load_err_d = load_new_c;
      if (minute_adv_c) begin
        if (time_q.ls_min != DigitW'(9)) begin
          time_d.ls_min = time_q.ls_min + DigitW'(1);
        end else begin
          time_d.ls_min = '0;
          if (time_q.ms_min != DigitW'(5)) begin
            time_d.ms_min = time_q.ms_min + DigitW'(1);
          end else begin
            // Minute 59 -> 00: carry into hours
            time_d.ms_min = '0;
            hour_tick_d   = 1'b1;
            if ((time_q.ms_hr == DigitW'(2)) && (time_q.ls_hr == DigitW'(3))) begin
              time_d.ms_hr = '0;
              time_d.ls_hr = '0;
              day_tick_d   = 1'b1;
            end else if (time_q.ls_hr == DigitW'(9)) begin
              time_d.ls_hr = '0;
              time_d.ms_hr = time_q.ms_hr + DigitW'(1);
            end else begin
              time_d.ls_hr = time_q.ls_hr + DigitW'(1);
            end
          end
        end
      end
    end
  end

  // Time and strobe registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q      <= '0;
      hour_tick_q <= 1'b0;
      day_tick_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      time_q      <= time_d;
      hour_tick_q <= hour_tick_d;
      day_tick_q  <= day_tick_d;
      load_err_q  <= load_err_d;
    end
  end

  assign current_time = TimeW'(time_q);
  assign hour_tick    = hour_tick_q;
  assign day_tick     = day_tick_q;
  assign load_err     = load_err_q;

endmodule
